// File: rtl/uart_rx_device.sv
// ---------------------------------------------------------------------------
// uart_rx_device : 8N1 UART receiver with a read FIFO on the CPU device bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_device #(
  parameter int CLOCK_DIV       = 10,
  parameter int CLOCK_MULT      = 105,
  parameter int BAUD_RATE       = 9600,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        control,
  input  logic        write_enable,
  input  logic [7:0]  write_address,
  input  logic [15:0] data_in,
  input  logic        read_enable,
  input  logic [7:0]  read_address,
  output logic [15:0] data_out,
  output logic        data_ready
);

  localparam int BIT_CLOCKS = int'((longint'(12_000_000) * longint'(CLOCK_MULT)) /
                                   (longint'(CLOCK_DIV) * longint'(BAUD_RATE)));
  localparam int CNT_W = $clog2(BIT_CLOCKS);
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLOCKS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CLOCKS / 2 - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FIFO_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                       sync1_q, sync2_q;
  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 idx_q, idx_d;
  logic [7:0]                 shift_q, shift_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
  logic                       overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic [15:0]                data_out_q, data_out_d;
  logic [7:0]                 mem_q [DEPTH];

  logic        push, frame_err_set, pop, full, push_ok, rd_hit, clr_hit;
  logic [3:0]  count_nib;
  logic [15:0] status;
  logic        unused_bits;

  assign unused_bits = ^{data_in[15:3], data_in[0]};

  // Receiver FSM; only the synchronized rx (sync2_q) is ever observed.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          if (!sync2_q) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          push          = sync2_q;
          frame_err_set = !sync2_q;
          state_d       = IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO and register file; a pop frees the slot a same-cycle push needs.
  always_comb begin
    rd_hit    = control && read_enable;
    clr_hit   = control && write_enable && (write_address == 8'h01);
    pop       = rd_hit && (read_address == 8'h00) && (count_q != '0);
    full      = (count_q == FIFO_FULL);
    push_ok   = push && (!full || pop);
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    overflow_d  = (push && full && !pop) || (overflow_q && !(clr_hit && data_in[1]));
    frame_err_d = frame_err_set || (frame_err_q && !(clr_hit && data_in[2]));
    count_nib   = 4'(count_q);
    status      = {4'h0, count_nib, 5'h00, frame_err_q, overflow_q, data_ready};
    data_out_d  = data_out_q;
    if (rd_hit) begin
      case (read_address)
        8'h00:   data_out_d = (count_q != '0) ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
        8'h01:   data_out_d = status;
        default: data_out_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      data_out_q  <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign data_out   = data_out_q;
  assign data_ready = (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_device.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_device : directed self-checking bench for uart_rx_device
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_device;
  localparam int BC = 8;

  logic        clk = 1'b0;
  logic        reset, rx, control, write_enable, read_enable;
  logic [7:0]  write_address, read_address;
  logic [15:0] data_in, data_out;
  logic        data_ready;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  uart_rx_device #(
    .CLOCK_DIV(1), .CLOCK_MULT(1), .BAUD_RATE(1_500_000), .FIFO_ADDR_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .control(control),
    .write_enable(write_enable), .write_address(write_address), .data_in(data_in),
    .read_enable(read_enable), .read_address(read_address),
    .data_out(data_out), .data_ready(data_ready)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [15:0] d);
    @(posedge clk); #1;
    control = 1'b1; read_enable = 1'b1; read_address = addr;
    @(posedge clk); #1;
    control = 1'b0; read_enable = 1'b0;
    d = data_out;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] d);
    @(posedge clk); #1;
    control = 1'b1; write_enable = 1'b1; write_address = addr; data_in = d;
    @(posedge clk); #1;
    control = 1'b0; write_enable = 1'b0;
  endtask

  // Drives one 8N1 frame; optionally issues a data read or a reset at a given bit-clock index.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at,
                            input int reset_at, output logic [15:0] pop_data);
    logic [9:0] frame;
    frame    = {stop_bit, b, 1'b0};
    pop_data = 16'h0000;
    for (int c = 0; c < 10 * BC; c++) begin
      @(posedge clk); #1;
      if (c == pop_at + 1) begin
        control = 1'b0; read_enable = 1'b0; pop_data = data_out;
      end
      if (c == reset_at) begin
        reset = 1'b1; rx = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      rx = frame[c / BC];
      if (c == pop_at) begin
        control = 1'b1; read_enable = 1'b1; read_address = 8'h00;
      end
    end
    @(posedge clk); #1;
    rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    logic [15:0] dummy;
    send_frame(b, 1'b1, -10, -10, dummy);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
    checks++;
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h expected 0000", d); end
    bus_read(8'h00, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_empty_read: got %h expected 0000", d); end
  endtask

  task automatic test_byte_receive;
    logic [15:0] d;
    send(8'hA5);
    idle(2);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL byte_ready: got %b expected 1", data_ready); end
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0101) begin errors++; $display("FAIL byte_status: got %h expected 0101", d); end
    // A deselected read must neither pop nor touch data_out.
    @(posedge clk); #1;
    control = 1'b0; read_enable = 1'b1; read_address = 8'h00;
    @(posedge clk); #1;
    read_enable = 1'b0;
    checks++;
    if (data_out !== 16'h0101 || data_ready !== 1'b1) begin
      errors++; $display("FAIL byte_deselected: got %h/%b expected 0101/1", data_out, data_ready);
    end
    bus_read(8'h00, d);
    checks++;
    if (d !== 16'h00A5) begin errors++; $display("FAIL byte_data: got %h expected 00a5", d); end
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL byte_ready_after: got %b expected 0", data_ready); end
    idle(5);
    checks++;
    if (data_out !== 16'h00A5) begin errors++; $display("FAIL byte_hold: got %h expected 00a5", data_out); end
    bus_read(8'h05, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL byte_bad_addr: got %h expected 0000", d); end
  endtask

  task automatic test_glitch;
    logic [15:0] d;
    @(posedge clk); #1; rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready: got %b expected 0", data_ready); end
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL glitch_status: got %h expected 0000", d); end
    send(8'h3C);
    bus_read(8'h00, d);
    checks++;
    if (d !== 16'h003C) begin errors++; $display("FAIL glitch_next_byte: got %h expected 003c", d); end
  endtask

  task automatic test_frame_error;
    logic [15:0] d;
    send_frame(8'h55, 1'b0, -10, -10, d);
    idle(20);
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL frame_err_status: got %h expected 0004", d); end
    bus_write(8'h01, 16'h0004);
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL frame_err_clear: got %h expected 0000", d); end
  endtask

  task automatic test_overflow;
    logic [15:0] d;
    for (int i = 1; i <= 9; i++) send(8'(i));
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0803) begin errors++; $display("FAIL overflow_status: got %h expected 0803", d); end
    // Back-to-back reads: read_enable stays high for nine consecutive cycles.
    @(posedge clk); #1;
    control = 1'b1; read_enable = 1'b1; read_address = 8'h00;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin control = 1'b0; read_enable = 1'b0; end
      checks++;
      if (data_out !== ((i <= 8) ? 16'(i) : 16'h0000)) begin
        errors++; $display("FAIL overflow_read%0d: got %h expected %h", i, data_out,
                            (i <= 8) ? 16'(i) : 16'h0000);
      end
    end
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL overflow_sticky: got %h expected 0002", d); end
    bus_write(8'h01, 16'h0002);
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL overflow_clear: got %h expected 0000", d); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    for (int i = 1; i <= 8; i++) send(8'(i));
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0801) begin errors++; $display("FAIL collide_full: got %h expected 0801", d); end
    // Read lands on the same edge as the stop-bit sample (79 edges after the frame starts).
    send_frame(8'h09, 1'b1, 78, -10, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL collide_pop: got %h expected 0001", d); end
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0801) begin errors++; $display("FAIL collide_status: got %h expected 0801", d); end
    for (int i = 2; i <= 9; i++) begin
      bus_read(8'h00, d);
      checks++;
      if (d !== 16'(i)) begin errors++; $display("FAIL collide_read%0d: got %h expected %h", i, d, 16'(i)); end
    end
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL collide_final: got %h expected 0000", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] d;
    send(8'h11);
    send(8'h22);
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0201) begin errors++; $display("FAIL midreset_queued: got %h expected 0201", d); end
    send_frame(8'hC3, 1'b1, -10, 42, d);
    checks++;
    if (data_out !== 16'h0000 || data_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%b expected 0000/0", data_out, data_ready);
    end
    idle(20);
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL midreset_status: got %h expected 0000", d); end
    send(8'h7E);
    bus_read(8'h01, d);
    checks++;
    if (d !== 16'h0101) begin errors++; $display("FAIL midreset_next_status: got %h expected 0101", d); end
    bus_read(8'h00, d);
    checks++;
    if (d !== 16'h007E) begin errors++; $display("FAIL midreset_next_byte: got %h expected 007e", d); end
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; control = 1'b0;
    write_enable = 1'b0; read_enable = 1'b0;
    write_address = 8'h00; read_address = 8'h00; data_in = 16'h0000;
    idle(3);
    reset = 1'b0;
    idle(3);
    test_reset();
    test_byte_receive();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
